mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares the single downstream memory port between the instruction-fetch side (read-only) and the data side of the rv32i pipeline (read/write with byte mask). It sits between the IF/MEM stage memory interfaces (or their caches) and physical memory. It grants one transaction at a time, registers the winner's request onto the memory port, and routes the response back. The data side has priority, with a bounded-starvation guarantee for fetch.

## Interface
Parameters:
- MAX_D_STREAK, default 4: maximum consecutive data grants while fetch is waiting; the next grant then goes to fetch. Legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_read  in  1  fetch read request; held until i_resp.
- i_addr  in  32  fetch byte address.
- i_resp  out  1  fetch transaction complete; i_rdata valid this cycle.
- i_rdata  out  32  fetch read data.
- d_read  in  1  data read request; held until d_resp.
- d_write  in  1  data write request; held until d_resp.
- d_addr  in  32  data byte address.
- d_wdata  in  32  data write data.
- d_wmask  in  4  data byte-enable mask (rv32i_mem_wmask).
- d_resp  out  1  data transaction complete.
- d_rdata  out  32  data read data.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  32  memory address, passed through unaltered.
- mem_wdata  out  32  memory write data.
- mem_wmask  out  4  memory byte mask; 4'b0000 on reads.
- mem_resp  in  1  memory completion, one-cycle pulse.
- mem_rdata  in  32  memory read data, valid with mem_resp.

## Operation
- States: IDLE, BUSY_I, BUSY_D. Reset state: IDLE.
- IDLE, no request: stay.
- IDLE, only i_read: grant fetch, go to BUSY_I.
- IDLE, only data request (d_read|d_write): grant data, go to BUSY_D.
- IDLE, both pending: grant data unless streak == MAX_D_STREAK, in which case grant fetch.
- Streak counter (4 bits): +1 on each data grant made while i_read=1 (saturating at MAX_D_STREAK); cleared on every fetch grant; unchanged on a data grant with i_read=0.
- On a grant, register the winner's addr/wdata/wmask/strobe into the mem_* outputs. Fetch: mem_read=1, mem_wmask=0, mem_wdata=0.
- d_read and d_write both high: treated as a write (mem_write=1, mem_read=0).
- BUSY_x: mem_* outputs are held stable. Requester input changes are ignored.
- BUSY_x with mem_resp=1: drop mem_read/mem_write at the edge, return to IDLE. In the same cycle assert x_resp combinationally (x_resp = mem_resp & state==BUSY_x), with x_rdata = mem_rdata.
- The non-granted response output stays 0. i_rdata/d_rdata may show mem_rdata at any time; they are only meaningful with their resp.
- mem_resp in IDLE: ignored, no resp output.

## Timing
- Reset values: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, mem_wmask=0, i_resp=0, d_resp=0, streak=0, state IDLE.
- Grant latency: request sampled in IDLE at cycle N; mem strobe high from cycle N+1.
- Response latency: 0 cycles, mem_resp to x_resp is combinational.
- Turnaround: after mem_resp at cycle M, the arbiter is in IDLE at M+1. The earliest next strobe is at M+2.
- Requesters must drop their request the cycle after x_resp. A request still high at M+1 is treated as a new request.
- Reset asserted mid-transaction: all outputs immediately go to their reset values and state goes to IDLE. The in-flight transaction is abandoned, and a later mem_resp is ignored.

## Test plan
- Fetch only: i_read=1, i_addr=0x0000_0060; memory responds 3 cycles after the strobe with 0x0000_0013 -> mem_read high with mem_addr=0x60 from N+1, i_resp=1 with i_rdata=0x13 for one cycle, d_resp never asserts.
- Data write: d_write=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_wmask=4'b0011 -> mem_write=1 with the same addr/data/mask held until mem_resp, mem_read=0, d_resp pulses once.
- Simultaneous contention, MAX_D_STREAK=4: i_read and d_read both held continuously, every transaction re-requested immediately -> grant order D,D,D,D,I,D,D,D,D,I.
- Requester change mid-transaction: during BUSY_D, change d_addr 0x100 to 0x200 and raise i_read -> mem_addr stays 0x100 until mem_resp; fetch is granted at the next IDLE only if d_read has dropped or the streak is full.
- Async reset: assert rst low two cycles into a BUSY_I read -> mem_read=0 and all outputs zero immediately without a clock edge. After release, a stray mem_resp produces no i_resp/d_resp.
- Spurious mem_resp in IDLE with no requests -> no resp outputs, state stays IDLE, streak unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters; data has
// priority, but fetch is guaranteed a grant after MAX_D_STREAK consecutive data grants.
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_read,
    input  logic [31:0] i_addr,
    output logic        i_resp,
    output logic [31:0] i_rdata,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    output logic        d_resp,
    output logic [31:0] d_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t     state, state_nxt;
    logic [3:0] streak;
    logic       d_req, streak_full, grant_i, grant_d;

    assign d_req       = d_read | d_write;
    assign streak_full = streak == STREAK_MAX;
    assign grant_i     = state == IDLE && i_read && (!d_req || streak_full);
    assign grant_d     = state == IDLE && d_req && !(i_read && streak_full);

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;

    always_comb begin
        state_nxt = state;
        if (grant_i)
            state_nxt = BUSY_I;
        else if (grant_d)
            state_nxt = BUSY_D;
        else if (state != IDLE && mem_resp)
            state_nxt = IDLE;
    end

    always_comb begin
        i_resp  = mem_resp && state == BUSY_I;
        d_resp  = mem_resp && state == BUSY_D;
        i_rdata = i_resp ? mem_rdata : 32'h0;
        d_rdata = d_resp ? mem_rdata : 32'h0;
    end

    // Streak only grows while fetch is actually being passed over.
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            streak <= '0;
        else if (grant_i)
            streak <= '0;
        else if (grant_d && i_read)
            streak <= streak_full ? streak : streak + 4'd1;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else if (grant_i) begin
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else if (grant_d) begin
            mem_read  <= !d_write;
            mem_write <= d_write;
            mem_addr  <= d_addr;
            mem_wdata <= d_write ? d_wdata : 32'h0;
            mem_wmask <= d_write ? d_wmask : 4'h0;
        end else if (state != IDLE && mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant order, hold, response routing and async reset.
module tb_mem_port_arbiter;
    logic        clk = 0, rst = 0;
    logic        i_read = 0, d_read = 0, d_write = 0, mem_resp = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic [3:0]  d_wmask = 0;
    logic        i_resp, d_resp, mem_read, mem_write;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    int          total = 0, bad = 0;

    mem_port_arbiter #(.MAX_D_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wmask(d_wmask), .d_resp(d_resp), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        string exp_order, got;
        logic  seen;
        cyc(); cyc(); settle();
        chk("rst_mem_read", 32'(mem_read), 0);
        chk("rst_mem_write", 32'(mem_write), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wmask", 32'(mem_wmask), 0);
        chk("rst_resps", {30'b0, i_resp, d_resp}, 0);
        rst = 1;

        // fetch only
        cyc(); i_read = 1; i_addr = 32'h60;
        cyc(); settle();
        chk("f_mem_read", 32'(mem_read), 1);
        chk("f_mem_addr", mem_addr, 32'h60);
        chk("f_mem_wmask", 32'(mem_wmask), 0);
        cyc(); cyc(); settle();
        chk("f_hold_addr", mem_addr, 32'h60);
        chk("f_no_resp_yet", 32'(i_resp), 0);
        cyc(); mem_resp = 1; mem_rdata = 32'h13; settle();
        chk("f_i_resp", 32'(i_resp), 1);
        chk("f_i_rdata", i_rdata, 32'h13);
        chk("f_d_resp", 32'(d_resp), 0);
        cyc(); mem_resp = 0; i_read = 0; settle();
        chk("f_read_drop", 32'(mem_read), 0);
        chk("f_i_resp_drop", 32'(i_resp), 0);

        // data write
        cyc(); d_write = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_wmask = 4'b0011;
        cyc(); settle();
        chk("w_mem_write", 32'(mem_write), 1);
        chk("w_mem_read", 32'(mem_read), 0);
        chk("w_mem_addr", mem_addr, 32'h100);
        chk("w_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("w_mem_wmask", 32'(mem_wmask), 32'h3);
        cyc(); settle();
        chk("w_hold_wdata", mem_wdata, 32'hDEADBEEF);
        cyc(); mem_resp = 1; mem_rdata = 32'h5; settle();
        chk("w_d_resp", 32'(d_resp), 1);
        chk("w_i_resp", 32'(i_resp), 0);
        cyc(); mem_resp = 0; d_write = 0; settle();
        chk("w_write_drop", 32'(mem_write), 0);
        chk("w_d_resp_drop", 32'(d_resp), 0);

        // contention: both held, expect D x4 then I, twice
        exp_order = "DDDDIDDDDI"; got = "";
        i_read = 1; d_read = 1; i_addr = 32'h60; d_addr = 32'h100;
        for (int k = 0; k < 10; k++) begin
            seen = 0;
            for (int w = 0; w < 6 && !seen; w++) begin
                cyc(); settle();
                seen = mem_read | mem_write;
            end
            chk($sformatf("c_grant_seen_%0d", k), 32'(seen), 1);
            got = {got, (mem_addr == 32'h60) ? "I" : "D"};
            mem_resp = 1;
            cyc(); mem_resp = 0;
        end
        i_read = 0; d_read = 0;
        chk("c_order", (got == exp_order) ? 32'h1 : 32'h0, 1);
        if (got != exp_order) $display("order got=%s", got);

        // requester change during BUSY_D
        cyc(); d_read = 1; d_addr = 32'h100;
        cyc(); settle();
        chk("m_addr0", mem_addr, 32'h100);
        d_addr = 32'h200; i_read = 1; i_addr = 32'h64;
        cyc(); settle();
        chk("m_addr_held", mem_addr, 32'h100);
        chk("m_read_held", 32'(mem_read), 1);
        mem_resp = 1; mem_rdata = 32'hAB; settle();
        chk("m_d_resp", 32'(d_resp), 1);
        chk("m_d_rdata", d_rdata, 32'hAB);
        chk("m_i_resp", 32'(i_resp), 0);
        cyc(); mem_resp = 0; d_read = 0;
        cyc(); settle();
        chk("m_fetch_addr", mem_addr, 32'h64);
        mem_resp = 1; settle();
        chk("m_fetch_resp", 32'(i_resp), 1);
        cyc(); mem_resp = 0; i_read = 0;

        // async reset two cycles into a fetch
        cyc(); i_read = 1; i_addr = 32'h44;
        cyc(); cyc(); #2; rst = 0; settle();
        chk("r_mem_read", 32'(mem_read), 0);
        chk("r_mem_addr", mem_addr, 0);
        chk("r_resps", {30'b0, i_resp, d_resp}, 0);
        i_read = 0;
        cyc(); rst = 1;
        cyc(); mem_resp = 1; mem_rdata = 32'h77; settle();
        chk("r_stray_resp", {30'b0, i_resp, d_resp}, 0);
        chk("r_stray_rdata", i_rdata | d_rdata, 0);

        // spurious mem_resp in IDLE, then read+write treated as write
        cyc(); settle();
        chk("s_idle_strobes", {30'b0, mem_read, mem_write}, 0);
        mem_resp = 0; d_read = 1; d_write = 1; d_addr = 32'h300; d_wmask = 4'hF; d_wdata = 32'h1234;
        cyc(); settle();
        chk("s_rw_write", {30'b0, mem_read, mem_write}, 32'h1);
        chk("s_rw_wmask", 32'(mem_wmask), 32'hF);
        mem_resp = 1; settle();
        chk("s_rw_resp", 32'(d_resp), 1);
        cyc(); mem_resp = 0; d_read = 0; d_write = 0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
